// File: rtl/reg_file_scoreboard.sv
// MIPS register file with per-register in-flight producer scoreboard.
// Ports: rs/rt async reads + busy, WB write port, issue/flush, pending_count.
module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_count
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  logic [ADDR_W:0]     r_count;

  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic                w_wr_en;
  logic                w_byp_rs;
  logic                w_byp_rt;
  logic                w_zero_rs;
  logic                w_zero_rt;

  // Writes to r0 are dropped when it is hardwired.
  assign w_wr_en = regWrite &
                   ~((ZERO_REG != 0) && (wr_addr == '0));

  assign w_byp_rs  = (BYPASS != 0) && regWrite &&
                     (wr_addr == rs_addr);
  assign w_byp_rt  = (BYPASS != 0) && regWrite &&
                     (wr_addr == rt_addr);
  assign w_zero_rs = (ZERO_REG != 0) && (rs_addr == '0);
  assign w_zero_rt = (ZERO_REG != 0) && (rt_addr == '0);

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (w_zero_rs)
      rs_data = '0;
    else if (w_byp_rs)
      rs_data = wr_data;
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (w_zero_rt)
      rt_data = '0;
    else if (w_byp_rt)
      rt_data = wr_data;
  end

  // r0 pending is never set when hardwired, so it is never busy.
  assign rs_busy = r_pend[rs_addr] & ~w_byp_rs;
  assign rt_busy = r_pend[rt_addr] & ~w_byp_rt;

  // A new issue to i wins over a simultaneous writeback to i:
  // the writeback belongs to the older producer.
  always_comb begin
    w_pend_nxt = r_pend;
    if (flush) begin
      w_pend_nxt = '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (issue_en && (issue_addr == ADDR_W'(i)))
          w_pend_nxt[i] = 1'b1;
        else if (regWrite && (wr_addr == ADDR_W'(i)))
          w_pend_nxt[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0)
      w_pend_nxt[0] = 1'b0;
  end

  // Count is taken from the next-state vector so the
  // registered count matches the registered bits.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_pend_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= '0;
      r_count <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  assign pending_count = r_count;

endmodule
